dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store path, replacing the zero-latency combinational data memory with a request/ready handshake.
- Serves word reads and byte-enabled writes with a programmable number of wait states.
- Flags misaligned and out-of-range accesses.
- Sits between the core's load/store interface (or a future multi-cycle bus master) and a word-organised storage array.

---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_word_ram.sv | 25 ++
 rtl/dmem_responder.sv | 91 +++++++++
 tb/tb_dmem_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int WORD_BYTES = 4;
    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < WORD_BYTES; i++) r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/dmem_word_ram.sv
// dmem_word_ram: single-port word storage with byte-lane writes and registered read.
module dmem_word_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= byte_merge(mem_q[addr_i], wdata_i, be_i);
            rdata_q <= mem_q[addr_i];
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: request/ready target for the core's load/store path with
// programmable wait states and misaligned/out-of-range fault reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           we_q, err_q, rd_q;
    logic [31:0]    addr_q, wdata_q;
    logic [3:0]     be_q;
    logic           idle, cur_we, fault, to_resp;
    logic [31:0]    cur_addr, cur_wdata, off, ram_rdata;
    logic [3:0]     cur_be;
    // With zero wait states the commit edge is the capture edge, so live inputs feed the decode.
    assign idle      = state_q == IDLE;
    assign cur_we    = idle ? we    : we_q;
    assign cur_addr  = idle ? addr  : addr_q;
    assign cur_wdata = idle ? wdata : wdata_q;
    assign cur_be    = idle ? be    : be_q;
    assign off       = cur_addr - ADDR_BASE;
    assign fault     = (|off[1:0]) || (cur_addr < ADDR_BASE) || ((off >> (AW + 2)) != 32'd0);
    assign to_resp   = state_d == RESP && state_q != RESP;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = req ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE;
                cnt_d   = req ? CNT_INIT : cnt_q;
            end
            WAIT: begin
                state_d = (cnt_q == '0) ? RESP : WAIT;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idle && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
            err_q <= to_resp && fault;
            rd_q  <= to_resp && !fault && !cur_we;
        end
    end
    dmem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk     (clk),
        .en_i    (to_resp && !fault),
        .we_i    (cur_we),
        .addr_i  (off[AW+1:2]),
        .wdata_i (cur_wdata),
        .be_i    (cur_be),
        .rdata_o (ram_rdata)
    );
    assign ready = state_q == RESP;
    assign err   = err_q;
    assign rdata = rd_q ? ram_rdata : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a 2-wait-state and a 0-wait-state responder.
module tb_dmem_responder;
    logic        clk = 1'b0, reset = 1'b1, req2 = 1'b0, req0 = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        rdy2, err2, rdy0, err0;
    logic [31:0] rd2, rd0;
    int          n_vec = 0, n_err = 0;
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [31:0] b2b [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_BASE(32'h0)) u_ws2 (
        .clk(clk), .reset(reset), .req(req2), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(rdy2), .rdata(rd2), .err(err2));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_BASE(32'h0)) u_ws0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(rdy0), .rdata(rd0), .err(err0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xact(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] r, output logic er, output int l);
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b;
        if (sel == 0) req0 = 1'b1; else req2 = 1'b1;
        @(posedge clk);
        l = 0; r = '0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((sel == 0) ? rdy0 : rdy2) begin
                l = i;
                r = (sel == 0) ? rd0 : rd2;
                er = (sel == 0) ? err0 : err2;
                break;
            end
        end
        req0 = 1'b0; req2 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", {31'd0, rdy2 | rdy0}, 32'd0);
            chk("rst_rdata", rd2 | rd0, 32'd0);
            chk("rst_err", {31'd0, err2 | err0}, 32'd0);
        end
        reset = 1'b0;
        xact(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
        chk("wr_lat", lat, 3);
        chk("wr_err", {31'd0, e}, 32'd0);
        chk("wr_rdata", rd, 32'd0);
        @(negedge clk);
        chk("wr_pulse", {31'd0, rdy2}, 32'd0);
        xact(2, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("rd_lat", lat, 3);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", {31'd0, e}, 32'd0);
        xact(2, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
        xact(2, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e, lat);
        xact(2, 1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        chk("merge", rd, 32'h11BB33DD);
        xact(2, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, e, lat);
        chk("be0_lat", lat, 3);
        chk("be0_err", {31'd0, e}, 32'd0);
        xact(2, 1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        chk("be0_keep", rd, 32'h11BB33DD);
        xact(2, 1'b0, 32'h22, 32'h0, 4'h0, rd, e, lat);
        chk("mis_lat", lat, 3);
        chk("mis_err", {31'd0, e}, 32'd1);
        chk("mis_rdata", rd, 32'd0);
        xact(2, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, e, lat);
        xact(2, 1'b1, 32'h400, 32'h12345678, 4'hF, rd, e, lat);
        chk("oor_err", {31'd0, e}, 32'd1);
        xact(2, 1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
        chk("oor_keep", rd, 32'hCAFEF00D);
        chk("oor_keep_err", {31'd0, e}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            xact(0, 1'b1, 32'h40 + 32'(4 * k), b2b[k], 4'hF, rd, e, lat);
            chk("ws0_wr_lat", lat, 1);
        end
        @(negedge clk);
        we = 1'b0; be = 4'h0; addr = 32'h40; req0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_ready", {31'd0, rdy0}, 32'd1);
            chk("b2b_rdata", rd0, b2b[k]);
            addr = 32'h40 + 32'(4 * (k + 1));
            @(negedge clk);
            chk("b2b_gap", {31'd0, rdy0}, 32'd0);
        end
        req0 = 1'b0;
        @(negedge clk);
        we = 1'b1; addr = 32'h30; wdata = 32'h5555AAAA; be = 4'hF; req2 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        req2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst_ready", {31'd0, rdy2}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_ready", {31'd0, rdy2}, 32'd0);
        end
        xact(2, 1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
        chk("dropped_wr", rd, 32'h0);
        chk("dropped_lat", lat, 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
